// File: rtl/asip_pkg.sv
// Shared definitions for the ASIP memory stage: operand-type codes,
// sequencer state type and default geometry.
package asip_pkg;

    localparam int LANES_DEF  = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    localparam logic [1:0] OP_SCALAR = 2'b00;
    localparam logic [1:0] OP_VECTOR = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mem_sequencer.sv
// Memory-stage sequencer: splits a scalar or vector load/store into one
// single-element memory access per lane and assembles load results.
//
//   state  | meaning
//   IDLE   | waiting for a memory instruction (Start_i)
//   ACCESS | one request per lane, advancing on Mem_Ack_i
//   DONE   | one-cycle completion pulse, Start_i ignored
module mem_sequencer
    import asip_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                      Clk_i,
    input  logic                      Rst_ni,
    input  logic                      Start_i,
    input  logic                      MemWE_i,
    input  logic [1:0]                OpType_i,
    input  logic [ADDR_W-1:0]         Addr_i,
    input  logic [LANES*DATA_W-1:0]   StoreData_i,
    output logic                      Mem_Req_o,
    input  logic                      Mem_Ack_i,
    output logic [ADDR_W-1:0]         Mem_Addr_o,
    output logic                      Mem_WE_o,
    output logic [DATA_W-1:0]         Mem_WData_o,
    input  logic [DATA_W-1:0]         Mem_RData_i,
    output logic [LANES*DATA_W-1:0]   LoadData_o,
    output logic                      Mem_Finished_o
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    seq_state_e               state_q;
    logic [LW-1:0]            lane_q;
    logic [LW-1:0]            last_lane_q;
    logic                     we_q;
    logic [ADDR_W-1:0]        base_q;
    logic [LANES*DATA_W-1:0]  sdata_q;
    logic [LANES*DATA_W-1:0]  load_q;

    logic in_access;
    assign in_access = (state_q == ACCESS);

    // Request side is a pure function of registered state, so reset clears it at once.
    assign Mem_Req_o      = in_access;
    assign Mem_WE_o       = in_access & we_q;
    assign Mem_Addr_o     = in_access ? (base_q + ADDR_W'(lane_q)) : '0;
    assign Mem_WData_o    = in_access ? sdata_q[lane_q*DATA_W +: DATA_W] : '0;
    assign LoadData_o     = load_q;
    assign Mem_Finished_o = (state_q == DONE) | ((state_q == IDLE) & ~Start_i);

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            last_lane_q <= '0;
            we_q        <= 1'b0;
            base_q      <= '0;
            sdata_q     <= '0;
            load_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start_i) begin
                        we_q        <= MemWE_i;
                        last_lane_q <= (OpType_i == OP_VECTOR) ? LW'(LANES - 1) : '0;
                        base_q      <= Addr_i;
                        sdata_q     <= StoreData_i;
                        lane_q      <= '0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (Mem_Ack_i) begin
                        if (!we_q) begin
                            load_q[lane_q*DATA_W +: DATA_W] <= Mem_RData_i;
                        end
                        if (lane_q == last_lane_q) begin
                            state_q <= DONE;
                        end else begin
                            lane_q <= lane_q + LW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameters SHALL be: LANES, default 4, vector element count; DATA_W, default 8, element width in bits; ADDR_W, default 8, memory address width in bits.
REQ-002 Clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Start_i  input  1  a memory instruction is present in the memory stage; held high until the pipeline advances.
REQ-005 MemWE_i  input  1  1 = store, 0 = load.
REQ-006 OpType_i  input  2  operand type: 01 = vector; any other value = scalar.
REQ-007 Addr_i  input  ADDR_W  base address.
REQ-008 StoreData_i  input  LANES*DATA_W  store data; lane k occupies bits [k*DATA_W +: DATA_W]; scalar ops use lane 0 only.
REQ-009 Mem_Req_o  output  1  memory access request.
REQ-010 Mem_Ack_i  input  1  memory accepts the request this cycle (and, for reads, returns data).
REQ-011 Mem_Addr_o  output  ADDR_W  access address.
REQ-012 Mem_WE_o  output  1  access is a write.
REQ-013 Mem_WData_o  output  DATA_W  write data.
REQ-014 Mem_RData_i  input  DATA_W  read data, valid in the Mem_Ack_i cycle.
REQ-015 LoadData_o  output  LANES*DATA_W  assembled load result, same lane packing as StoreData_i.
REQ-016 Mem_Finished_o  output  1  memory stage has no outstanding work and may advance; feeds the control unit's Mem_Finished input.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-018 IDLE with Start_i=1 SHALL latch MemWE_i, the lane count (LANES for vector, 1 for scalar), Addr_i and StoreData_i, clear the lane counter, and go to ACCESS.
REQ-019 Mem_Finished_o SHALL be combinational: 1 in IDLE when Start_i=0, 0 in IDLE when Start_i=1, 0 in ACCESS, and 1 in DONE.
REQ-020 In ACCESS, Mem_Req_o SHALL be 1, Mem_Addr_o SHALL be (latched base + lane) mod 2^ADDR_W, Mem_WE_o SHALL equal the latched MemWE, and Mem_WData_o SHALL equal latched store lane[lane].
REQ-021 Request outputs SHALL stay stable while Mem_Ack_i=0; there is no timeout.
REQ-022 ACCESS with Mem_Ack_i=1 on a load SHALL write Mem_RData_i into LoadData_o lane[lane]; the other lanes SHALL be unchanged.
REQ-023 ACCESS with Mem_Ack_i=1 on the last lane SHALL go to DONE; otherwise the lane counter SHALL increment and the FSM SHALL stay in ACCESS.
REQ-024 DONE SHALL last exactly one cycle, ignore Start_i, and return to IDLE; LoadData_o SHALL hold its value until the next load writes it.
REQ-025 Minimum latency from Start_i sampled to Mem_Finished_o=1 SHALL be (lane count + 1) cycles when Mem_Ack_i is always 1.
REQ-026 Mem_Ack_i outside ACCESS SHALL be ignored.
REQ-027 Mem_Req_o, Mem_WE_o, Mem_Addr_o and Mem_WData_o SHALL be 0 outside ACCESS.

Reset
REQ-028 Rst_ni=0 SHALL immediately force: state IDLE, lane counter 0, latched fields 0, LoadData_o 0, Mem_Req_o 0, Mem_WE_o 0, Mem_Addr_o 0, Mem_WData_o 0.
REQ-029 Reset during ACCESS SHALL abandon the transfer with no further requests; lanes already written to memory are not rolled back.

Structure
REQ-030 Shared package asip_pkg SHALL hold the OpType encodings (OP_SCALAR=00, OP_VECTOR=01), the state enum type, and the LANES/DATA_W/ADDR_W defaults.
REQ-031 The block SHALL be a single module; no sub-module is required.

Verification
REQ-032 Scalar load: Addr_i=0x10, OpType_i=00, MemWE_i=0, Ack always 1, RData=0xAB -> one request at 0x10, LoadData_o lane0=0xAB, Mem_Finished_o=1 two cycles after start.
REQ-033 Vector store: Addr_i=0x20, OpType_i=01, StoreData_i={0x44,0x33,0x22,0x11} -> writes 0x11,0x22,0x33,0x44 to 0x20..0x23 in four consecutive cycles, then DONE.
REQ-034 Ack stalls: vector load with Mem_Ack_i low for 3 cycles before each lane -> address and request held stable, 4 lanes captured in order, Mem_Finished_o low until DONE.
REQ-035 Wrap-around: vector load at Addr_i=0xFE -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-036 Reset mid-op: Rst_ni low after lane 1 ack -> Mem_Req_o=0 and LoadData_o=0 immediately; after release, IDLE with Mem_Finished_o=1.
REQ-037 Back-to-back: Start_i held high through DONE, then a new vector op -> no duplicate access during DONE, new op starts from IDLE.
